// File: rtl/alarm_time_sequencer_if.sv
// Status/control bundle between the alarm clock control unit and the time sequencer.
// slave = sequencer side, master = control unit / stimulus side.
interface alarm_time_sequencer_if;
  logic       Tick_1s;
  logic       Mode;
  logic       Inc;
  logic       Alarm_En;
  logic       EN_SNZ;
  logic       EN_STOP;
  logic [4:0] Hours;
  logic [5:0] Minutes;
  logic [5:0] Seconds;
  logic [4:0] Alarm_H;
  logic [5:0] Alarm_M;
  logic [2:0] Set_State;
  logic       AA;
  logic       C0;
  logic       CS0;

  modport slave (
    input  Tick_1s, Mode, Inc, Alarm_En, EN_SNZ, EN_STOP,
    output Hours, Minutes, Seconds, Alarm_H, Alarm_M, Set_State, AA, C0, CS0
  );

  modport master (
    output Tick_1s, Mode, Inc, Alarm_En, EN_SNZ, EN_STOP,
    input  Hours, Minutes, Seconds, Alarm_H, Alarm_M, Set_State, AA, C0, CS0
  );
endinterface

// File: rtl/alarm_time_sequencer.sv
// Time-of-day / alarm registers, set-mode FSM, snooze and ring-timeout counters.
// All outputs registered, 1 Clk from input; no backpressure (pulse/level inputs only).
module alarm_time_sequencer #(
  parameter int unsigned SNOOZE_SEC  = 300,
  parameter int unsigned RING_SEC    = 60,
  parameter int unsigned ALARM_RST_H = 6
) (
  input  logic                  Clk,
  input  logic                  Reset,
  alarm_time_sequencer_if.slave bus
);

  localparam logic [2:0]  RUN    = 3'd0;
  localparam logic [2:0]  SET_TH = 3'd1;
  localparam logic [2:0]  SET_TM = 3'd2;
  localparam logic [2:0]  SET_AH = 3'd3;
  localparam logic [2:0]  SET_AM = 3'd4;

  localparam logic [15:0] SNZ_LD = 16'(SNOOZE_SEC);
  localparam logic [7:0]  RNG_LD = 8'(RING_SEC);
  localparam logic [4:0]  AH_RST = 5'(ALARM_RST_H);

  logic [2:0]  state_q, state_d;
  logic [4:0]  hr_q, hr_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic [4:0]  al_h_q, al_h_d;
  logic [5:0]  al_m_q, al_m_d;
  logic        aa_q, aa_d;
  logic [15:0] snz_cnt_q, snz_cnt_d;
  logic        c0_q, c0_d;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
  logic        cs0_q, cs0_d;

  logic        time_run;
  logic        in_run;
  logic        inc_th, inc_tm, inc_ah, inc_am;
  logic        clr_sec;

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; unused codes fall back to RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.Mode) state_d = SET_TH;
      SET_TH:  if (bus.Mode) state_d = SET_TM;
      SET_TM:  if (bus.Mode) state_d = SET_AH;
      SET_AH:  if (bus.Mode) state_d = SET_AM;
      SET_AM:  if (bus.Mode) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM output decode; Mode takes precedence over Inc
  always_comb begin
    in_run   = (state_q == RUN);
    time_run = (state_q == RUN) || (state_q == SET_AH) || (state_q == SET_AM);
    inc_th   = bus.Inc && !bus.Mode && (state_q == SET_TH);
    inc_tm   = bus.Inc && !bus.Mode && (state_q == SET_TM);
    inc_ah   = bus.Inc && !bus.Mode && (state_q == SET_AH);
    inc_am   = bus.Inc && !bus.Mode && (state_q == SET_AM);
    clr_sec  = bus.Mode && (state_q == SET_TM);
  end

  // Time-of-day and alarm datapath
  always_comb begin
    hr_d   = hr_q;
    min_d  = min_q;
    sec_d  = sec_q;
    al_h_d = al_h_q;
    al_m_d = al_m_q;

    if (bus.Tick_1s && time_run) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    // Set-field increments never carry into the neighbouring field
    if (inc_th) hr_d   = (hr_q == 5'd23)   ? 5'd0 : hr_q + 5'd1;
    if (inc_tm) min_d  = (min_q == 6'd59)  ? 6'd0 : min_q + 6'd1;
    if (inc_ah) al_h_d = (al_h_q == 5'd23) ? 5'd0 : al_h_q + 5'd1;
    if (inc_am) al_m_d = (al_m_q == 6'd59) ? 6'd0 : al_m_q + 6'd1;
    if (clr_sec) sec_d = 6'd0;

    // Only the tick landing on hh:mm:00 fires, so the pulse cannot repeat within the minute
    aa_d = bus.Tick_1s && in_run && bus.Alarm_En &&
           (hr_d == al_h_q) && (min_d == al_m_q) && (sec_d == 6'd0);
  end

  // Snooze and ring-timeout countdowns, saturating at zero
  always_comb begin
    snz_cnt_d  = SNZ_LD;
    ring_cnt_d = RNG_LD;
    if (bus.EN_SNZ) begin
      snz_cnt_d = (bus.Tick_1s && snz_cnt_q != 16'd0) ? snz_cnt_q - 16'd1 : snz_cnt_q;
    end
    if (bus.EN_STOP) begin
      ring_cnt_d = (bus.Tick_1s && ring_cnt_q != 8'd0) ? ring_cnt_q - 8'd1 : ring_cnt_q;
    end
    c0_d  = bus.EN_SNZ  && (snz_cnt_d == 16'd0);
    cs0_d = bus.EN_STOP && (ring_cnt_d == 8'd0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hr_q       <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      al_h_q     <= AH_RST;
      al_m_q     <= 6'd0;
      aa_q       <= 1'b0;
      snz_cnt_q  <= SNZ_LD;
      c0_q       <= 1'b0;
      ring_cnt_q <= RNG_LD;
      cs0_q      <= 1'b0;
    end else begin
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      al_h_q     <= al_h_d;
      al_m_q     <= al_m_d;
      aa_q       <= aa_d;
      snz_cnt_q  <= snz_cnt_d;
      c0_q       <= c0_d;
      ring_cnt_q <= ring_cnt_d;
      cs0_q      <= cs0_d;
    end
  end

  assign bus.Hours     = hr_q;
  assign bus.Minutes   = min_q;
  assign bus.Seconds   = sec_q;
  assign bus.Alarm_H   = al_h_q;
  assign bus.Alarm_M   = al_m_q;
  assign bus.Set_State = state_q;
  assign bus.AA        = aa_q;
  assign bus.C0        = c0_q;
  assign bus.CS0       = cs0_q;

endmodule

// File: tb/tb_alarm_time_sequencer.sv
// Directed bench for alarm_time_sequencer: inputs change and outputs are sampled on negedge.
module tb_alarm_time_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alarm_time_sequencer_if bus ();

  alarm_time_sequencer #(
    .SNOOZE_SEC (3),
    .RING_SEC   (2),
    .ALARM_RST_H(6)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock cycle with the given pulse inputs, returning on the following negedge
  task automatic step(input logic t, input logic m, input logic i);
    bus.Tick_1s = t;
    bus.Mode    = m;
    bus.Inc     = i;
    @(negedge clk);
    bus.Tick_1s = 1'b0;
    bus.Mode    = 1'b0;
    bus.Inc     = 1'b0;
  endtask

  // Walk the set FSM from RUN: bump hours/minutes, clear seconds, tick seconds, back to RUN
  task automatic set_time(input int h_inc, input int m_inc, input int s_ticks);
    step(0, 1, 0);
    for (int k = 0; k < h_inc; k++) step(0, 0, 1);
    step(0, 1, 0);
    for (int k = 0; k < m_inc; k++) step(0, 0, 1);
    step(0, 1, 0);
    for (int k = 0; k < s_ticks; k++) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.Tick_1s  = 1'b0;
    bus.Mode     = 1'b0;
    bus.Inc      = 1'b0;
    bus.Alarm_En = 1'b0;
    bus.EN_SNZ   = 1'b0;
    bus.EN_STOP  = 1'b0;
    repeat (2) @(negedge clk);

    check_val("rst_hours", 32'(bus.Hours), 0);
    check_val("rst_minutes", 32'(bus.Minutes), 0);
    check_val("rst_seconds", 32'(bus.Seconds), 0);
    check_val("rst_alarm_h", 32'(bus.Alarm_H), 6);
    check_val("rst_alarm_m", 32'(bus.Alarm_M), 0);
    check_val("rst_state", 32'(bus.Set_State), 0);
    check_val("rst_flags", {29'd0, bus.AA, bus.C0, bus.CS0}, 0);
    rst = 1'b0;

    // Basic counting
    repeat (3) step(1, 0, 0);
    check_val("t1_seconds", 32'(bus.Seconds), 3);
    check_val("t1_hm", {bus.Hours, bus.Minutes}, 0);

    // Set mode: frozen seconds, hour wrap, Mode beats Inc, seconds cleared leaving SET_TM
    step(0, 1, 0);
    check_val("t5_state_th", 32'(bus.Set_State), 1);
    step(1, 0, 0);
    check_val("t5_sec_frozen", 32'(bus.Seconds), 3);
    repeat (25) step(0, 0, 1);
    check_val("t5_hours_wrap", 32'(bus.Hours), 1);
    step(0, 1, 1);
    check_val("t5_mode_wins_h", 32'(bus.Hours), 1);
    check_val("t5_mode_wins_m", 32'(bus.Minutes), 0);
    check_val("t5_state_tm", 32'(bus.Set_State), 2);
    step(0, 1, 0);
    check_val("t5_state_ah", 32'(bus.Set_State), 3);
    check_val("t5_sec_clear", 32'(bus.Seconds), 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check_val("t5_state_run", 32'(bus.Set_State), 0);
    check_val("t5_alarm_kept", {bus.Alarm_H, bus.Alarm_M}, {5'd6, 6'd0});

    // Day rollover from 01:00:00 to 23:59:58, then two ticks
    set_time(22, 59, 58);
    check_val("t2_pre_h", 32'(bus.Hours), 23);
    check_val("t2_pre_m", 32'(bus.Minutes), 59);
    check_val("t2_pre_s", 32'(bus.Seconds), 58);
    step(1, 0, 0);
    check_val("t2_5959_h", 32'(bus.Hours), 23);
    check_val("t2_5959_s", 32'(bus.Seconds), 59);
    step(1, 0, 0);
    check_val("t2_wrap", {bus.Hours, bus.Minutes, bus.Seconds}, 0);

    // Alarm match at 06:00:00
    set_time(5, 59, 59);
    check_val("t3_pre", {bus.Hours, bus.Minutes, bus.Seconds}, {5'd5, 6'd59, 6'd59});
    check_val("t3_pre_aa", 32'(bus.AA), 0);
    bus.Alarm_En = 1'b1;
    step(1, 0, 0);
    check_val("t3_aa_hit", 32'(bus.AA), 1);
    check_val("t3_time", {bus.Hours, bus.Minutes, bus.Seconds}, {5'd6, 6'd0, 6'd0});
    step(0, 0, 0);
    check_val("t3_aa_one_cycle", 32'(bus.AA), 0);
    step(1, 0, 0);
    check_val("t3_aa_no_retrig", 32'(bus.AA), 0);
    bus.Alarm_En = 1'b0;
    set_time(23, 59, 59);
    step(1, 0, 0);
    check_val("t3_dis_time", {bus.Hours, bus.Minutes, bus.Seconds}, {5'd6, 6'd0, 6'd0});
    check_val("t3_aa_disabled", 32'(bus.AA), 0);

    // Snooze countdown with SNOOZE_SEC = 3
    bus.EN_SNZ = 1'b1;
    step(0, 0, 0);
    check_val("t4_c0_idle", 32'(bus.C0), 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check_val("t4_c0_tick2", 32'(bus.C0), 0);
    step(1, 0, 0);
    check_val("t4_c0_tick3", 32'(bus.C0), 1);
    step(1, 0, 0);
    check_val("t4_c0_sat", 32'(bus.C0), 1);
    bus.EN_SNZ = 1'b0;
    step(0, 0, 0);
    check_val("t4_c0_drop", 32'(bus.C0), 0);
    bus.EN_SNZ = 1'b1;
    step(1, 0, 0);
    step(1, 0, 0);
    check_val("t4_rerun_tick2", 32'(bus.C0), 0);
    step(1, 0, 0);
    check_val("t4_rerun_tick3", 32'(bus.C0), 1);
    bus.EN_SNZ = 1'b0;
    step(0, 0, 0);
    check_val("t4_c0_off", 32'(bus.C0), 0);

    // Ring timeout with RING_SEC = 2, reset mid-count overriding a tick
    bus.EN_STOP = 1'b1;
    step(1, 0, 0);
    check_val("t6_cs0_tick1", 32'(bus.CS0), 0);
    rst = 1'b1;
    step(1, 0, 0);
    rst = 1'b0;
    check_val("t6_cs0_rst", 32'(bus.CS0), 0);
    check_val("t6_ring_reload", 32'(dut.ring_cnt_q), 2);
    check_val("t6_time_rst", {bus.Hours, bus.Minutes, bus.Seconds}, 0);
    step(1, 0, 0);
    check_val("t6_cs0_after1", 32'(bus.CS0), 0);
    step(1, 0, 0);
    check_val("t6_cs0_after2", 32'(bus.CS0), 1);
    bus.EN_STOP = 1'b0;
    step(0, 0, 0);
    check_val("t6_cs0_drop", 32'(bus.CS0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
